// File: rtl/csa_cpa_accumulator_if.sv
// Beat-in / result-out handshake bundle for csa_cpa_accumulator.
// Carries out_ovf only when CSA_ACC_OVF_EN is defined.
interface csa_cpa_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BEATS  = 4
);
  localparam int unsigned ACC_W = DATA_WIDTH * (NUM_BEATS + 1);
  localparam int unsigned IDX_W = $clog2(NUM_BEATS);

  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] in_carry;
  logic [2*DATA_WIDTH-1:0] in_sum;
  logic [IDX_W-1:0]        beat_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
`ifdef CSA_ACC_OVF_EN
  logic                    out_ovf;
`endif

  modport master (
    output in_valid, in_carry, in_sum, out_ready,
    input  in_ready, beat_idx, out_valid, out_data
`ifdef CSA_ACC_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_carry, in_sum, out_ready,
    output in_ready, beat_idx, out_valid, out_data
`ifdef CSA_ACC_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/csa_cpa_accumulator.sv
// Resolves carry-save {carry,sum} beats and accumulates NUM_BEATS of them, beat i weighted
// by 2^(DATA_WIDTH*i). Define CSA_ACC_OVF_EN to add the sticky out_ovf carry-out flag.
module csa_cpa_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BEATS  = 4
) (
  input logic                    clk,
  input logic                    rst,
  csa_cpa_accumulator_if.slave   bus
);
  localparam int unsigned PAIR_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = DATA_WIDTH * (NUM_BEATS + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_BEATS);

  typedef logic [ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {StAcc, StFlush, StOut} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  beat_idx_q;
  logic              s1_valid_q;
  logic [PAIR_W-1:0] s1_val_q;
  logic [IDX_W-1:0]  s1_idx_q;
  acc_t              acc_q;
  logic              out_valid_q;

  logic              accept;
  logic              last_beat;
  logic [PAIR_W-1:0] beat_val;
  acc_t              addend;

  assign bus.in_ready  = (state_q == StAcc);
  assign accept        = bus.in_valid && (state_q == StAcc);
  assign last_beat     = (beat_idx_q == IDX_W'(NUM_BEATS - 1));
  // Carry has weight 2; its MSB falls off the 2*DATA_WIDTH result.
  assign beat_val      = bus.in_sum + (bus.in_carry << 1);
  assign addend        = acc_t'(s1_val_q) << (DATA_WIDTH * s1_idx_q);

  assign bus.beat_idx  = beat_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;

`ifdef CSA_ACC_OVF_EN
  logic [ACC_W:0] acc_sum;
  logic           ovf_q;
  assign acc_sum     = {1'b0, acc_q} + {1'b0, addend};
  assign bus.out_ovf = ovf_q;
`else
  acc_t acc_sum;
  assign acc_sum = acc_q + addend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      beat_idx_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_idx_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef CSA_ACC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_val_q <= beat_val;
        s1_idx_q <= beat_idx_q;
      end

      if (s1_valid_q) begin
        acc_q <= acc_sum[ACC_W-1:0];
`ifdef CSA_ACC_OVF_EN
        if (acc_sum[ACC_W]) ovf_q <= 1'b1;
`endif
      end

      case (state_q)
        StAcc: begin
          if (accept) begin
            if (last_beat) begin
              beat_idx_q <= '0;
              state_q    <= StFlush;
            end else begin
              beat_idx_q <= beat_idx_q + IDX_W'(1);
            end
          end
        end
        // Hold until the final beat has landed in acc; result is presented the cycle after.
        StFlush: begin
          if (!s1_valid_q) begin
            state_q     <= StOut;
            out_valid_q <= 1'b1;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf_q       <= 1'b0;
`endif
            state_q     <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_cpa_accumulator.sv
// Scoreboard bench for csa_cpa_accumulator: a reference model pushes expected results on
// the final beat; a negedge monitor pops and compares them at each output handshake.
`timescale 1ns/1ps
module tb_csa_cpa_accumulator;
  localparam int unsigned DW = 16;
  localparam int unsigned NB = 4;
  localparam int unsigned AW = DW * (NB + 1);

  typedef logic [AW:0] wide_t;
  typedef struct packed {
    logic [AW-1:0] data;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_cpa_accumulator_if #(.DATA_WIDTH(DW), .NUM_BEATS(NB)) bus ();
  csa_cpa_accumulator #(.DATA_WIDTH(DW), .NUM_BEATS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_q[$];
  logic [AW-1:0] m_acc;
  logic          m_ovf;
  int            m_idx;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
    m_idx = 0;
  endtask

  task automatic model_beat(input logic [31:0] s, input logic [31:0] c);
    logic [31:0] v;
    wide_t t;
    exp_t e;
    v = s + (c << 1);
    t = {1'b0, m_acc} + (wide_t'(v) << (DW * m_idx));
    m_acc = t[AW-1:0];
    m_ovf = m_ovf | t[AW];
    m_idx++;
    if (m_idx == NB) begin
      e.data = m_acc;
      e.ovf  = m_ovf;
      sb_q.push_back(e);
      model_reset();
    end
  endtask

  // Leaves in_valid high so back-to-back beats need no bubble.
  task automatic send_beat(input logic [31:0] s, input logic [31:0] c, input int gap);
    int w;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_carry = c;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!bus.in_ready) check("in_ready_wait", 0, 1);
    check("beat_idx", bus.beat_idx, m_idx);
    tick();
    model_beat(s, c);
  endtask

  task automatic send_txn(input logic [31:0] s [NB], input logic [31:0] c [NB],
                          input int gap [NB]);
    for (int i = 0; i < NB; i++) send_beat(s[i], c[i], gap[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || !bus.in_ready) && w < 100) begin
      tick();
      w++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", bus.out_data, e.data);
`ifdef CSA_ACC_OVF_EN
        check("out_ovf", bus.out_ovf, e.ovf);
`endif
      end
    end
  end

  initial begin
    logic [31:0] rs [NB];
    logic [31:0] rc [NB];
    int          rg [NB];
    int          w;

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    rst = 1'b1;
    repeat (2) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_beat_idx", bus.beat_idx, 0);
    rst = 1'b0;

    // Basic with latency: last beat accepted at edge T, out_valid only after T+2.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NB; i++) send_beat(32'd1, 32'd0, 0);
    bus.in_valid = 1'b0;
    check("lat_t0_valid", bus.out_valid, 0);
    tick();
    check("lat_t1_valid", bus.out_valid, 0);
    check("lat_t1_ready", bus.in_ready, 0);
    tick();
    check("lat_t2_valid", bus.out_valid, 1);
    check("basic_data", bus.out_data, 80'h0001_0001_0001_0001);
    drain();

    // Carry weight, then carry MSB dropped.
    send_txn('{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd1, 32'd0, 32'd0, 32'd0}, '{0, 0, 0, 0});
    send_txn('{32'd0, 32'd0, 32'd0, 32'd0}, '{32'h8000_0000, 32'd0, 32'd0, 32'd0},
             '{0, 0, 0, 0});
    drain();

    // Bubbles: in_valid pattern 1,0,0,1,1,0,1.
    send_txn('{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd0, 32'd0, 32'd0, 32'd0}, '{0, 2, 0, 1});
    drain();

    // Backpressure with in_valid held high while the result waits.
    bus.out_ready = 1'b0;
    send_txn('{32'd7, 32'd8, 32'd9, 32'd10}, '{32'd3, 32'd0, 32'd1, 32'd0}, '{0, 0, 0, 0});
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'd5;
    bus.in_carry = 32'd0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      tick();
      w++;
    end
    check("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      if (sb_q.size() != 0) check("bp_data_stable", bus.out_data, sb_q[0].data);
      else check("bp_queue", 0, 1);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_beat_idx", bus.beat_idx, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    send_txn('{32'd5, 32'd6, 32'd0, 32'hFFFF}, '{32'd0, 32'd2, 32'd0, 32'd0}, '{0, 0, 0, 0});
    drain();

    // Reset mid-transaction discards the partial beats.
    send_beat(32'd9, 32'd9, 0);
    send_beat(32'd9, 32'd9, 0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_beat_idx", bus.beat_idx, 0);
    send_txn('{32'd2, 32'd0, 32'd0, 32'd1}, '{32'd0, 32'd0, 32'd0, 32'd0}, '{0, 0, 0, 0});
    drain();

    // Random beats and gaps.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NB; i++) begin
        rs[i] = $urandom();
        rc[i] = $urandom();
        rg[i] = $urandom_range(0, 2);
      end
      send_txn(rs, rc, rg);
    end
    drain();

`ifdef CSA_ACC_OVF_EN
    send_txn('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
             '{32'd0, 32'd0, 32'd0, 32'd0}, '{0, 0, 0, 0});
    send_txn('{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0}, '{0, 0, 0, 0});
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
